// File: rtl/maj_pkg.sv
// Shared helpers for the majority vote filter: popcount, default threshold
// and parameter legality predicates.
package maj_pkg;

  localparam int unsigned MAX_N_IN = 32;
  localparam int unsigned MAX_WIN  = 63;

  function automatic int unsigned popcount(input logic [MAX_N_IN-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < MAX_N_IN; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

  function automatic int unsigned default_thresh(input int unsigned n);
    return n / 2 + 1;
  endfunction

  function automatic bit n_in_ok(input int unsigned n);
    return (n >= 1) && (n <= MAX_N_IN);
  endfunction

  function automatic bit win_ok(input int unsigned w);
    return (w >= 1) && (w <= MAX_WIN) && (w % 2 == 1);
  endfunction

endpackage

// File: rtl/maj_window.sv
// Temporal stage: WIN-deep decision shift register with running sum,
// fill counter and strict-majority compare once the window is full.
module maj_window
  import maj_pkg::*;
#(
  parameter  int unsigned WIN = 7,
  localparam int unsigned SW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          shift,
  input  logic          bit_in,
  output logic          out_valid,
  output logic          out_maj,
  output logic [SW-1:0] win_sum,
  output logic          win_full
);

  localparam logic [SW-1:0] WIN_C  = SW'(WIN);
  localparam logic [SW-1:0] HALF_C = SW'(WIN / 2);

  logic [WIN-1:0] sr;
  logic [WIN-1:0] sr_next;
  logic [SW-1:0]  fill;
  logic [SW-1:0]  fill_next;
  logic [SW-1:0]  sum_next;
  logic           oldest;
  logic           full_next;
  logic           maj_next;

  // Sum update uses modular arithmetic; the true result always lies in 0..WIN.
  always_comb begin
    oldest    = win_full & sr[WIN-1];
    sr_next   = (sr << 1) | WIN'(bit_in);
    sum_next  = win_sum + SW'(bit_in) - SW'(oldest);
    fill_next = (fill == WIN_C) ? fill : fill + SW'(1);
    full_next = (fill_next == WIN_C);
    maj_next  = full_next & (sum_next > HALF_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      fill      <= '0;
      win_sum   <= '0;
      win_full  <= 1'b0;
      out_maj   <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      sr        <= '0;
      fill      <= '0;
      win_sum   <= '0;
      win_full  <= 1'b0;
      out_maj   <= 1'b0;
      out_valid <= 1'b0;
    end else if (shift) begin
      sr        <= sr_next;
      fill      <= fill_next;
      win_sum   <= sum_next;
      win_full  <= full_next;
      out_maj   <= maj_next;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/majority_vote_filter.sv
// Two-stage voter: spatial majority over N_IN bits with run-time threshold,
// then temporal majority over the last WIN accepted decisions.
module majority_vote_filter
  import maj_pkg::*;
#(
  parameter  int unsigned N_IN = 5,
  parameter  int unsigned WIN  = 7,
  localparam int unsigned PW   = $clog2(N_IN + 1),
  localparam int unsigned SW   = $clog2(WIN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_data,
  input  logic [PW-1:0]   thresh,
  output logic [PW-1:0]   pop_count,
  output logic            spatial_maj,
  output logic            out_valid,
  output logic            out_maj,
  output logic [SW-1:0]   win_sum,
  output logic            win_full
);

  if (!n_in_ok(N_IN)) begin : g_bad_n_in
    $error("majority_vote_filter: N_IN must be in 1..32");
  end
  if (!win_ok(WIN)) begin : g_bad_win
    $error("majority_vote_filter: WIN must be odd and in 1..63");
  end

  logic [PW-1:0] pop_next;
  logic          spatial_next;
  int unsigned   eff_thr;
  logic          s1_valid;

  // Thresholds above N_IN are legal and simply never match.
  always_comb begin
    eff_thr      = (thresh == '0) ? default_thresh(N_IN) : 32'(thresh);
    pop_next     = PW'(popcount(32'(in_data)));
    spatial_next = (32'(pop_next) >= eff_thr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_count   <= '0;
      spatial_maj <= 1'b0;
      s1_valid    <= 1'b0;
    end else if (clear) begin
      pop_count   <= '0;
      spatial_maj <= 1'b0;
      s1_valid    <= 1'b0;
    end else if (in_valid) begin
      pop_count   <= pop_next;
      spatial_maj <= spatial_next;
      s1_valid    <= 1'b1;
    end else begin
      s1_valid    <= 1'b0;
    end
  end

  maj_window #(
    .WIN (WIN)
  ) u_window (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .shift     (s1_valid),
    .bit_in    (spatial_maj),
    .out_valid (out_valid),
    .out_maj   (out_maj),
    .win_sum   (win_sum),
    .win_full  (win_full)
  );

endmodule

// File: tb/tb_majority_vote_filter.sv
// Directed bench for majority_vote_filter with N_IN=5, WIN=3.
module tb_majority_vote_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [4:0] in_data;
  logic [2:0] thresh;
  logic [2:0] pop_count;
  logic       spatial_maj;
  logic       out_valid;
  logic       out_maj;
  logic [1:0] win_sum;
  logic       win_full;

  int checks = 0;
  int errors = 0;

  majority_vote_filter #(.N_IN(5), .WIN(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .thresh      (thresh),
    .pop_count   (pop_count),
    .spatial_maj (spatial_maj),
    .out_valid   (out_valid),
    .out_maj     (out_maj),
    .win_sum     (win_sum),
    .win_full    (win_full)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic clr, input logic v, input logic [4:0] d, input logic [2:0] th);
    clear = clr; in_valid = v; in_data = d; thresh = th;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (pop_count !== 3'd0)   begin errors++; $display("FAIL reset pop_count got %0d exp 0", pop_count); end
    checks++; if (spatial_maj !== 1'b0) begin errors++; $display("FAIL reset spatial_maj got %0b exp 0", spatial_maj); end
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset out_valid got %0b exp 0", out_valid); end
    checks++; if (out_maj !== 1'b0)     begin errors++; $display("FAIL reset out_maj got %0b exp 0", out_maj); end
    checks++; if (win_sum !== 2'd0)     begin errors++; $display("FAIL reset win_sum got %0d exp 0", win_sum); end
    checks++; if (win_full !== 1'b0)    begin errors++; $display("FAIL reset win_full got %0b exp 0", win_full); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_default_thresh;
    logic [4:0] d [5] = '{5'b00111, 5'b01011, 5'b11111, 5'b00000, 5'b00000};
    logic       v [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int e_pop [5] = '{3, 3, 5, 5, 5};
    int e_ov  [5] = '{0, 1, 1, 1, 0};
    int e_sum [5] = '{0, 1, 2, 3, 3};
    int e_maj [5] = '{0, 0, 0, 1, 1};
    int e_ful [5] = '{0, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, v[i], d[i], 3'd0);
      checks++; if (pop_count !== 3'(e_pop[i])) begin errors++; $display("FAIL dflt pop_count[%0d] got %0d exp %0d", i, pop_count, e_pop[i]); end
      checks++; if (spatial_maj !== 1'b1)       begin errors++; $display("FAIL dflt spatial_maj[%0d] got %0b exp 1", i, spatial_maj); end
      checks++; if (out_valid !== 1'(e_ov[i]))  begin errors++; $display("FAIL dflt out_valid[%0d] got %0b exp %0d", i, out_valid, e_ov[i]); end
      checks++; if (win_sum !== 2'(e_sum[i]))   begin errors++; $display("FAIL dflt win_sum[%0d] got %0d exp %0d", i, win_sum, e_sum[i]); end
      checks++; if (out_maj !== 1'(e_maj[i]))   begin errors++; $display("FAIL dflt out_maj[%0d] got %0b exp %0d", i, out_maj, e_maj[i]); end
      checks++; if (win_full !== 1'(e_ful[i]))  begin errors++; $display("FAIL dflt win_full[%0d] got %0b exp %0d", i, win_full, e_ful[i]); end
    end
  endtask

  task automatic test_thresh_sweep;
    logic [4:0] d  [5] = '{5'b01110, 5'b11110, 5'b11111, 5'b11111, 5'b00001};
    logic [2:0] th [5] = '{3'd4, 3'd4, 3'd6, 3'd5, 3'd1};
    int e_pop [5] = '{3, 4, 5, 5, 1};
    int e_sp  [5] = '{0, 1, 0, 1, 1};
    cyc(1'b1, 1'b0, 5'd0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, d[i], th[i]);
      checks++; if (pop_count !== 3'(e_pop[i])) begin errors++; $display("FAIL thr pop_count[%0d] got %0d exp %0d", i, pop_count, e_pop[i]); end
      checks++; if (spatial_maj !== 1'(e_sp[i])) begin errors++; $display("FAIL thr spatial_maj[%0d] got %0b exp %0d", i, spatial_maj, e_sp[i]); end
    end
  endtask

  task automatic test_wrap;
    logic [4:0] d [6] = '{5'b11111, 5'b11111, 5'b11111, 5'b00000, 5'b00000, 5'b11111};
    int e_sum [6] = '{1, 2, 3, 2, 1, 1};
    int e_maj [6] = '{0, 0, 1, 1, 0, 0};
    int e_ful [6] = '{0, 0, 1, 1, 1, 1};
    cyc(1'b1, 1'b0, 5'd0, 3'd0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, i < 6, (i < 6) ? d[i] : 5'd0, 3'd0);
      if (i >= 1) begin
        checks++; if (out_valid !== 1'b1)           begin errors++; $display("FAIL wrap out_valid[%0d] got %0b exp 1", i-1, out_valid); end
        checks++; if (win_sum !== 2'(e_sum[i-1]))   begin errors++; $display("FAIL wrap win_sum[%0d] got %0d exp %0d", i-1, win_sum, e_sum[i-1]); end
        checks++; if (out_maj !== 1'(e_maj[i-1]))   begin errors++; $display("FAIL wrap out_maj[%0d] got %0b exp %0d", i-1, out_maj, e_maj[i-1]); end
        checks++; if (win_full !== 1'(e_ful[i-1]))  begin errors++; $display("FAIL wrap win_full[%0d] got %0b exp %0d", i-1, win_full, e_ful[i-1]); end
      end
    end
  endtask

  task automatic test_gaps;
    logic v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int pulses = 0;
    cyc(1'b1, 1'b0, 5'd0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, v[i], 5'b11111, 3'd0);
      if (out_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 2)       begin errors++; $display("FAIL gaps pulses got %0d exp 2", pulses); end
    checks++; if (win_sum !== 2'd2)  begin errors++; $display("FAIL gaps win_sum got %0d exp 2", win_sum); end
    checks++; if (win_full !== 1'b0) begin errors++; $display("FAIL gaps win_full got %0b exp 0", win_full); end
  endtask

  task automatic test_clear_collision;
    cyc(1'b1, 1'b0, 5'd0, 3'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, i < 3, 5'b11111, 3'd0);
    checks++; if (win_full !== 1'b1) begin errors++; $display("FAIL clr prefill win_full got %0b exp 1", win_full); end
    cyc(1'b1, 1'b1, 5'b11111, 3'd0);
    checks++; if (win_sum !== 2'd0)     begin errors++; $display("FAIL clr win_sum got %0d exp 0", win_sum); end
    checks++; if (win_full !== 1'b0)    begin errors++; $display("FAIL clr win_full got %0b exp 0", win_full); end
    checks++; if (out_maj !== 1'b0)     begin errors++; $display("FAIL clr out_maj got %0b exp 0", out_maj); end
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL clr out_valid got %0b exp 0", out_valid); end
    checks++; if (pop_count !== 3'd0)   begin errors++; $display("FAIL clr pop_count got %0d exp 0", pop_count); end
    checks++; if (spatial_maj !== 1'b0) begin errors++; $display("FAIL clr spatial_maj got %0b exp 0", spatial_maj); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 3'd0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr dropped out_valid[%0d] got %0b exp 0", i, out_valid); end
    end
    // Sample already in stage 1 when clear arrives must vanish too.
    cyc(1'b0, 1'b1, 5'b11111, 3'd0);
    checks++; if (spatial_maj !== 1'b1) begin errors++; $display("FAIL clr inflight spatial_maj got %0b exp 1", spatial_maj); end
    cyc(1'b1, 1'b0, 5'd0, 3'd0);
    cyc(1'b0, 1'b0, 5'd0, 3'd0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr inflight out_valid got %0b exp 0", out_valid); end
    checks++; if (win_sum !== 2'd0)   begin errors++; $display("FAIL clr inflight win_sum got %0d exp 0", win_sum); end
  endtask

  task automatic test_async_reset;
    cyc(1'b0, 1'b1, 5'b11111, 3'd0);
    cyc(1'b0, 1'b1, 5'b11111, 3'd0);
    clear = 1'b0; in_valid = 1'b1; in_data = 5'b11111;
    #2 rst = 1'b1;
    #1;
    checks++; if (pop_count !== 3'd0)   begin errors++; $display("FAIL arst pop_count got %0d exp 0", pop_count); end
    checks++; if (spatial_maj !== 1'b0) begin errors++; $display("FAIL arst spatial_maj got %0b exp 0", spatial_maj); end
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL arst out_valid got %0b exp 0", out_valid); end
    checks++; if (win_sum !== 2'd0)     begin errors++; $display("FAIL arst win_sum got %0d exp 0", win_sum); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    cyc(1'b0, 1'b1, 5'b00111, 3'd0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst early out_valid got %0b exp 0", out_valid); end
    cyc(1'b0, 1'b1, 5'b00001, 3'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst first out_valid got %0b exp 1", out_valid); end
    checks++; if (win_sum !== 2'd1)   begin errors++; $display("FAIL arst first win_sum got %0d exp 1", win_sum); end
    cyc(1'b0, 1'b0, 5'd0, 3'd0);
    checks++; if (win_sum !== 2'd1)   begin errors++; $display("FAIL arst second win_sum got %0d exp 1", win_sum); end
    checks++; if (out_maj !== 1'b0)   begin errors++; $display("FAIL arst second out_maj got %0b exp 0", out_maj); end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; thresh = '0;
    test_reset();
    test_default_thresh();
    test_thresh_sweep();
    test_wrap();
    test_gaps();
    test_clear_collision();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
